// File: rtl/pool1.sv
// pool1: 2x2/stride-2 max pooling plus requantization to unsigned 8 bits.
// Latches one IN_H x IN_W frame on each in_valid rising edge, then streams
// OUT_H x OUT_W pooled values, one per cycle, row-major.
// Optional build macro: POOL1_ROUND_EN (round half-up before the shift).
module pool1 #(
   parameter int IN_H  = 14,
   parameter int IN_W  = 13,
   parameter int OUT_H = 7,
   parameter int OUT_W = 6,
   parameter int CHAN  = 10,
   parameter int SHIFT = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic [3:0]          in_chan,
   input  logic signed [23:0]  in_buff [0:IN_H-1][0:IN_W-1],
   output logic                out_valid,
   output logic [7:0]          out_data,
   output logic [3:0]          out_chan,
   output logic [2:0]          out_row,
   output logic [2:0]          out_col,
   output logic                out_last,
   output logic                busy,
   output logic                overrun
);

   if (OUT_H != IN_H / 2 || OUT_W != IN_W / 2 || SHIFT < 1 || SHIFT > 16 ||
       CHAN < 1 || CHAN > 16 || OUT_H > 8 || OUT_W > 8) begin : g_bad_params
      $error("pool1: inconsistent parameters");
   end

   localparam logic [2:0] LAST_ROW = 3'(OUT_H - 1);
   localparam logic [2:0] LAST_COL = 3'(OUT_W - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state_q, state_d;
   logic               in_valid_d_q, in_valid_d_d;
   logic [3:0]         chan_q, chan_d;
   logic [2:0]         row_q, row_d, col_q, col_d;
   logic signed [23:0] frame_q [0:IN_H-1][0:IN_W-1];
   logic signed [23:0] frame_d [0:IN_H-1][0:IN_W-1];

   logic               out_valid_q, out_valid_d;
   logic [7:0]         out_data_q, out_data_d;
   logic [3:0]         out_chan_q, out_chan_d;
   logic [2:0]         out_row_q, out_row_d, out_col_q, out_col_d;
   logic               out_last_q, out_last_d;
   logic               busy_q, busy_d;
   logic               overrun_q, overrun_d;

   logic               edge_det;
   logic               last_win;
   logic [3:0]         r0, r1, c0, c1;
   logic signed [23:0] w00, w01, w10, w11, m_a, m_b, m_max;
   logic [23:0]        m_pos;
   logic [24:0]        q;
   logic [7:0]         q_sat;

   // Window fetch, signed max, ReLU clamp, shift and saturation.
   always_comb begin
      r0 = {row_q, 1'b0};
      r1 = {row_q, 1'b1};
      c0 = {col_q, 1'b0};
      c1 = {col_q, 1'b1};
      w00 = frame_q[r0][c0];
      w01 = frame_q[r0][c1];
      w10 = frame_q[r1][c0];
      w11 = frame_q[r1][c1];
      m_a   = (w00 > w01) ? w00 : w01;
      m_b   = (w10 > w11) ? w10 : w11;
      m_max = (m_a > m_b) ? m_a : m_b;
      m_pos = m_max[23] ? '0 : m_max;
`ifdef POOL1_ROUND_EN
      q = ({1'b0, m_pos} + (25'd1 << (SHIFT - 1))) >> SHIFT;
`else
      q = {1'b0, m_pos} >> SHIFT;
`endif
      q_sat = (q > 25'd255) ? 8'hFF : q[7:0];
   end

   // Next-state logic: edge detect, frame capture, window walk, output stage.
   always_comb begin
      edge_det     = in_valid & ~in_valid_d_q;
      last_win     = (row_q == LAST_ROW) && (col_q == LAST_COL);
      in_valid_d_d = in_valid;
      state_d      = state_q;
      chan_d       = chan_q;
      row_d        = row_q;
      col_d        = col_q;
      frame_d      = frame_q;
      out_valid_d  = 1'b0;
      out_last_d   = 1'b0;
      out_data_d   = out_data_q;
      out_chan_d   = out_chan_q;
      out_row_d    = out_row_q;
      out_col_d    = out_col_q;
      // busy stays up for the cycle in which the final element is presented
      busy_d       = (state_q == RUN);
      overrun_d    = overrun_q;
      case (state_q)
         IDLE: begin
            if (edge_det) begin
               frame_d = in_buff;
               chan_d  = in_chan;
               row_d   = '0;
               col_d   = '0;
               state_d = RUN;
               busy_d  = 1'b1;
            end
         end
         RUN: begin
            if (edge_det) overrun_d = 1'b1;
            out_valid_d = 1'b1;
            out_data_d  = q_sat;
            out_chan_d  = chan_q;
            out_row_d   = row_q;
            out_col_d   = col_q;
            if (last_win) begin
               out_last_d = 1'b1;
               state_d    = IDLE;
               row_d      = '0;
               col_d      = '0;
            end else if (col_q == LAST_COL) begin
               col_d = '0;
               row_d = row_q + 3'd1;
            end else begin
               col_d = col_q + 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Frame storage; contents are only meaningful after a capture.
   always_ff @(posedge clk) begin
      frame_q <= frame_d;
   end

   // Control FSM and registered outputs with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         in_valid_d_q <= 1'b0;
         chan_q       <= '0;
         row_q        <= '0;
         col_q        <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_chan_q   <= '0;
         out_row_q    <= '0;
         out_col_q    <= '0;
         out_last_q   <= 1'b0;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         in_valid_d_q <= in_valid_d_d;
         chan_q       <= chan_d;
         row_q        <= row_d;
         col_q        <= col_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_chan_q   <= out_chan_d;
         out_row_q    <= out_row_d;
         out_col_q    <= out_col_d;
         out_last_q   <= out_last_d;
         busy_q       <= busy_d;
         overrun_q    <= overrun_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;
   assign out_row   = out_row_q;
   assign out_col   = out_col_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_pool1.sv
// tb_pool1: directed self-checking bench for pool1 (default parameters).
// Expected values follow POOL1_ROUND_EN when the bench is built with it.
module tb_pool1;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic [3:0]         in_chan;
   logic signed [23:0] buff [0:13][0:12];
   logic               out_valid;
   logic [7:0]         out_data;
   logic [3:0]         out_chan;
   logic [2:0]         out_row;
   logic [2:0]         out_col;
   logic               out_last;
   logic               busy;
   logic               overrun;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_data [0:41];

   always #5 clk = ~clk;

   pool1 #(.IN_H(14), .IN_W(13), .OUT_H(7), .OUT_W(6), .CHAN(10), .SHIFT(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_chan(in_chan),
      .in_buff(buff), .out_valid(out_valid), .out_data(out_data),
      .out_chan(out_chan), .out_row(out_row), .out_col(out_col),
      .out_last(out_last), .busy(busy), .overrun(overrun)
   );

   // advance one clock and sample 1 time unit after the rising edge
   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // in_buff[i][j] = 256*(i*13+j); pooled value (2r+1)*13+2c+1, capped at 255
   task automatic fill_ramp;
      for (int i = 0; i < 14; i++)
         for (int j = 0; j < 13; j++)
            buff[i][j] = 24'(256 * (i * 13 + j));
      for (int r = 0; r < 7; r++)
         for (int c = 0; c < 6; c++) begin
            int v;
            v = (2 * r + 1) * 13 + 2 * c + 1;
            exp_data[r * 6 + c] = (v > 255) ? 8'd255 : 8'(v);
         end
   endtask

   task automatic test_reset;
      logic [21:0] got;
      rst = 1'b1; in_valid = 1'b1; in_chan = 4'd0;
      step; step;
      got = {out_valid, out_data, out_chan, out_row, out_col, out_last, busy, overrun};
      checks++;
      if (got !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0", got);
      end
      rst = 1'b0;
      step;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL reset_held_valid_edge: busy=%b expected 1", busy);
      end
      in_valid = 1'b0; rst = 1'b1;
      step;
      rst = 1'b0;
      step;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_during_run: busy=%b out_valid=%b expected 0 0", busy, out_valid);
      end
   endtask

   task automatic test_single_frame;
      logic [19:0] got, exp;
      fill_ramp;
      in_chan = 4'd3; in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_start: busy=%b out_valid=%b expected 1 0", busy, out_valid);
      end
      for (int n = 0; n < 42; n++) begin
         step;
         got = {out_valid, out_last, out_chan, out_row, out_col, out_data};
         exp = {1'b1, n == 41, 4'd3, 3'(n / 6), 3'(n % 6), exp_data[n]};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL single_elem%0d: got %h expected %h", n, got, exp);
         end
      end
      step;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL single_end: valid=%b busy=%b last=%b overrun=%b expected 0 0 0 0",
                  out_valid, busy, out_last, overrun);
      end
   endtask

   task automatic test_saturation;
      logic [19:0] got, exp;
      fill_ramp;
      buff[0][0] = 24'sh7FFFFF;
      exp_data[0] = 8'd255;
      buff[2][2] = -24'sd5; buff[2][3] = -24'sd5;
      buff[3][2] = -24'sd5; buff[3][3] = -24'sd5;
      exp_data[7] = 8'd0;
      for (int i = 0; i < 14; i++) buff[i][12] = 24'sh7FFFFF;
      in_chan = 4'd1; in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      for (int n = 0; n < 42; n++) begin
         step;
         got = {out_valid, out_last, out_chan, out_row, out_col, out_data};
         exp = {1'b1, n == 41, 4'd1, 3'(n / 6), 3'(n % 6), exp_data[n]};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL sat_elem%0d: got %h expected %h", n, got, exp);
         end
      end
      step;
   endtask

   task automatic test_rounding;
      logic [19:0] got, exp;
      for (int i = 0; i < 14; i++)
         for (int j = 0; j < 13; j++) buff[i][j] = '0;
      for (int n = 0; n < 42; n++) exp_data[n] = 8'd0;
      buff[0][0] = 24'sd383;
      buff[0][2] = 24'sd384;
      exp_data[0] = 8'd1;
`ifdef POOL1_ROUND_EN
      exp_data[1] = 8'd2;
`else
      exp_data[1] = 8'd1;
`endif
      in_chan = 4'd2; in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      for (int n = 0; n < 42; n++) begin
         step;
         got = {out_valid, out_last, out_chan, out_row, out_col, out_data};
         exp = {1'b1, n == 41, 4'd2, 3'(n / 6), 3'(n % 6), exp_data[n]};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL round_elem%0d: got %h expected %h", n, got, exp);
         end
      end
      step;
   endtask

   task automatic test_overrun;
      logic [19:0] got, exp;
      fill_ramp;
      in_chan = 4'd5; in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      for (int n = 0; n < 42; n++) begin
         if (n == 20) begin
            in_valid = 1'b1; in_chan = 4'd7;
            for (int i = 0; i < 14; i++)
               for (int j = 0; j < 13; j++) buff[i][j] = 24'sh7FFFFF;
         end
         if (n == 22) in_valid = 1'b0;
         step;
         got = {out_valid, out_last, out_chan, out_row, out_col, out_data};
         exp = {1'b1, n == 41, 4'd5, 3'(n / 6), 3'(n % 6), exp_data[n]};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL overrun_elem%0d: got %h expected %h", n, got, exp);
         end
      end
      checks++;
      if (overrun !== 1'b1) begin
         errors++;
         $display("FAIL overrun_flag: overrun=%b expected 1", overrun);
      end
      // third edge sampled at k+43, the earliest acceptable slot
      in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL overrun_restart: busy=%b out_valid=%b expected 1 0", busy, out_valid);
      end
      for (int n = 0; n < 42; n++) begin
         step;
         got = {out_valid, out_last, out_chan, out_row, out_col, out_data};
         exp = {1'b1, n == 41, 4'd7, 3'(n / 6), 3'(n % 6), 8'd255};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL overrun_third_elem%0d: got %h expected %h", n, got, exp);
         end
      end
      step;
      checks++;
      if (overrun !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL overrun_sticky: overrun=%b busy=%b expected 1 0", overrun, busy);
      end
   endtask

   task automatic test_reset_mid;
      logic [19:0] got, exp;
      fill_ramp;
      in_chan = 4'd4; in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      for (int n = 0; n < 10; n++) begin
         step;
         got = {out_valid, out_last, out_chan, out_row, out_col, out_data};
         exp = {1'b1, 1'b0, 4'd4, 3'(n / 6), 3'(n % 6), exp_data[n]};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL midrst_elem%0d: got %h expected %h", n, got, exp);
         end
      end
      rst = 1'b1;
      step;
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || out_last !== 1'b0) begin
         errors++;
         $display("FAIL midrst_clear: valid=%b busy=%b overrun=%b last=%b expected 0 0 0 0",
                  out_valid, busy, overrun, out_last);
      end
      for (int n = 0; n < 5; n++) begin
         step;
         checks++;
         if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_quiet%0d: valid=%b busy=%b expected 0 0", n, out_valid, busy);
         end
      end
      in_chan = 4'd6; in_valid = 1'b1;
      step;
      in_valid = 1'b0;
      step;
      got = {out_valid, out_last, out_chan, out_row, out_col, out_data};
      exp = {1'b1, 1'b0, 4'd6, 3'd0, 3'd0, exp_data[0]};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL midrst_restart: got %h expected %h", got, exp);
      end
      for (int n = 0; n < 42; n++) step;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL midrst_drain: busy=%b valid=%b expected 0 0", busy, out_valid);
      end
   endtask

   task automatic test_back_to_back;
      logic [19:0] got, exp;
      int count;
      fill_ramp;
      count = 0;
      for (int t = 0; t < 500; t++) begin
         if (t % 50 == 0 && t / 50 < 10) begin
            in_valid = 1'b1;
            in_chan  = 4'(t / 50);
         end else begin
            in_valid = 1'b0;
         end
         step;
         if (out_valid === 1'b1) begin
            int k;
            k = count % 42;
            got = {out_last, out_chan, out_row, out_col, out_data, 1'b0};
            exp = {k == 41, 4'(count / 42), 3'(k / 6), 3'(k % 6), exp_data[k], 1'b0};
            checks++;
            if (got !== exp || count >= 420) begin
               errors++;
               $display("FAIL b2b_out%0d: got %h expected %h", count, got, exp);
            end
            count++;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (count != 420 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL b2b_total: outputs=%0d overrun=%b expected 420 0", count, overrun);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_chan = 4'd0;
      for (int i = 0; i < 14; i++)
         for (int j = 0; j < 13; j++) buff[i][j] = '0;
      test_reset;
      test_single_frame;
      test_saturation;
      test_rounding;
      test_overrun;
      test_reset_mid;
      test_back_to_back;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
